dense1_output_requant_reader: RTL and testbench
===============================================

# dense1_output_requant_reader

Consumer at the far end of the 1600→128 dense layer's `start`/`done` + `read_addr`/`read_data` result port. It starts the upstream layer and waits for its `done`. It then reads all 128 int32 accumulators, applies ReLU, rounding right-shift and int8 saturation, and buffers the 128 int8 activations. The block also reports the argmax of the activations and serves them to the next dense layer through the same `start`/`done` + combinational byte read-port style.

## Interface
- `N_OUT`, 128: number of upstream outputs read; index width 7 bits.
- `SHIFT`, 8: requantization right-shift, 0..31; 0 means no shift and no rounding.
- `READ_LATENCY`, 1: cycles from `up_read_addr` driven to `up_read_data` valid (registered BRAM port B).

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin a run; sampled in IDLE or DONE only.
- `up_start` out 1: one-cycle start pulse to the upstream dense layer.
- `up_done` in 1: upstream completion, level; ignored outside WAIT_UP.
- `up_read_addr` out 32: upstream element index, 0..N_OUT-1 in bits [6:0], upper bits 0.
- `up_read_data` in 32: signed upstream accumulator.
- `rd_addr` in 7: downstream activation index.
- `rd_data` out 8: signed int8 activation at `rd_addr`, combinational from the buffer.
- `argmax` out 7: index of the largest activation.
- `max_val` out 8: value of the largest activation.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE, held until the next accepted `start`.

## Operation
- Reset values: state=IDLE; `up_start`=0, `up_read_addr`=0, `argmax`=0, `max_val`=0, `busy`=0, `done`=0. Buffer contents are not reset, so `rd_data` is undefined until the first DONE.
- States:
  - IDLE: on `start`, go to START_UP.
  - START_UP: `up_start`=1 for exactly this one cycle; go to WAIT_UP.
  - WAIT_UP: wait for `up_done`=1, then go to FETCH with issue index=0.
  - FETCH: drive `up_read_addr`=issue index and increment once per cycle; after index N_OUT-1 is issued, go to DRAIN.
  - DRAIN: finish the READ_LATENCY outstanding captures, then go to DONE.
  - DONE: `done`=1; on `start`, clear `done` and go to START_UP.
- `start` is ignored in START_UP, WAIT_UP, FETCH and DRAIN.
- Capture: the word for index k is sampled exactly READ_LATENCY cycles after `up_read_addr`=k is first driven. A shift-register of valid+index, depth READ_LATENCY, tracks which index each sample belongs to.
- Requant per word x, signed int32:
  - r = (x<0) ? 0 : x.
  - If SHIFT>0: y = (r + 2^(SHIFT-1)) >> SHIFT, computed in 33 bits with no overflow. If SHIFT=0: y = r.
  - Saturate: q = min(y, 127). Result is always 0..127.
- Write q into the buffer at entry k in the capture cycle.
- Argmax is a running compare in the capture cycle: update when q > current max (strict), so the lowest index wins ties. At the first capture of a run (k=0), max and argmax are loaded unconditionally.
- `argmax`/`max_val` are stable and final from DONE entry until the next START_UP. Intermediate values during FETCH/DRAIN are don't-care.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values. No `up_start` is issued until a new `start`.

## Timing
- `start` sampled in cycle 0 → `up_start` high in cycle 1 only.
- `up_done` first seen high in cycle t → `up_read_addr`=0 in cycle t+1, reaching N_OUT-1 in cycle t+N_OUT.
- Last capture in cycle t+N_OUT+READ_LATENCY; `done`=1 from cycle t+N_OUT+READ_LATENCY+1.
- With defaults: 130 cycles from seeing `up_done` to `done`.
- `rd_data` follows `rd_addr` combinationally in DONE.
- Reading `rd_data` while `busy`=1 returns a mix of old and new data and is not guaranteed.
- `up_read_addr` holds its last value (N_OUT-1) in DRAIN and DONE.

## Test plan
- Upstream model returns x=k·256 for index k, SHIFT=8, READ_LATENCY=1 → `rd_data[k]`=min(k,127). Check: `rd_data[5]`=5, `rd_data[127]`=127; `argmax`=127; `max_val`=127; `done` exactly 130 cycles after `up_done` is seen.
- Rounding and ReLU, SHIFT=8: x=-5000→0; x=127→0; x=128→1; x=383→1; x=384→2; x=0x7FFFFFFF→127 (saturated, no wrap).
- Ties: all x=0 except x[10]=x[90]=1280 → `max_val`=5, `argmax`=10.
- `start` pulses during WAIT_UP and FETCH → no second `up_start`, single completion. A `start` in DONE → `done` falls next cycle and `up_start` pulses once.
- READ_LATENCY=2 with an upstream that deliberately changes `up_read_data` every cycle → no off-by-one: each `rd_data[k]` matches the requantized x[k].
- `reset` asserted mid-FETCH at index 60 → same-cycle IDLE, `busy`=0, `done`=0. A following full run produces correct results.

Source files
------------

// File: rtl/dense1_output_requant_reader.sv
// Reads the int32 accumulators of the upstream dense layer, applies ReLU, a rounding right-shift
// and int8 saturation, and buffers the activations for the next layer. It also tracks the argmax
// of the activations.
module dense1_output_requant_reader #(
  parameter int unsigned N_OUT        = 128,
  parameter int unsigned SHIFT        = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       up_start,
  input  logic                       up_done,
  output logic [31:0]                up_read_addr,
  input  logic [31:0]                up_read_data,
  input  logic [$clog2(N_OUT)-1:0]   rd_addr,
  output logic [7:0]                 rd_data,
  output logic [$clog2(N_OUT)-1:0]   argmax,
  output logic [7:0]                 max_val,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned IdxW = $clog2(N_OUT);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_OUT - 1);
  // Half an LSB of the shifted result; zero when SHIFT is 0, so no rounding is applied.
  localparam logic [32:0] RoundBias = (33'd1 << SHIFT) >> 1;

  typedef enum logic [2:0] {
    StIdle,
    StStartUp,
    StWaitUp,
    StFetch,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0]         addr_q;
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [IdxW-1:0]         pipe_idx_q [READ_LATENCY];
  logic [7:0]              buf_q [N_OUT];
  logic [7:0]              max_q;
  logic [IdxW-1:0]         argmax_q;

  logic                    cap_vld;
  logic [IdxW-1:0]         cap_idx;
  logic [32:0]             rect;
  logic [32:0]             rounded;
  logic [6:0]              q;

  assign cap_vld = pipe_vld_q[READ_LATENCY-1];
  assign cap_idx = pipe_idx_q[READ_LATENCY-1];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StStartUp;
      StStartUp: state_d = StWaitUp;
      StWaitUp:  if (up_done) state_d = StFetch;
      StFetch:   if (addr_q == LastIdx) state_d = StDrain;
      // The last capture is the one tagged with the final index.
      StDrain:   if (cap_vld && (cap_idx == LastIdx)) state_d = StDone;
      StDone:    if (start) state_d = StStartUp;
      default:   state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    up_start = (state_q == StStartUp);
    busy     = (state_q != StIdle) && (state_q != StDone);
    done     = (state_q == StDone);
  end

  // Issue index: cleared when upstream completes, advanced once per FETCH cycle, then held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else if ((state_q == StWaitUp) && up_done) begin
      addr_q <= '0;
    end else if ((state_q == StFetch) && (addr_q != LastIdx)) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  assign up_read_addr = {{(32 - IdxW){1'b0}}, addr_q};

  // Valid+index delay line matching the upstream read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_idx_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= (state_q == StFetch);
      pipe_idx_q[0] <= addr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  // Requantization: ReLU, round-half-up right shift in 33 bits, saturate to 127.
  always_comb begin
    rect    = up_read_data[31] ? 33'd0 : {1'b0, up_read_data};
    rounded = (rect + RoundBias) >> SHIFT;
    q       = (rounded > 33'd127) ? 7'd127 : rounded[6:0];
  end

  // Activation buffer; contents are not reset.
  always_ff @(posedge clk) begin
    if (cap_vld) begin
      buf_q[cap_idx] <= {1'b0, q};
    end
  end

  assign rd_data = buf_q[rd_addr];

  // Running argmax; strict compare keeps the lowest index on ties, index 0 seeds the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q    <= '0;
      argmax_q <= '0;
    end else if (cap_vld && ((cap_idx == '0) || ({1'b0, q} > max_q))) begin
      max_q    <= {1'b0, q};
      argmax_q <= cap_idx;
    end
  end

  assign max_val = max_q;
  assign argmax  = argmax_q;

endmodule

// File: tb/tb_dense1_output_requant_reader.sv
// Directed bench: two instances (read latency 1 and 2) against behavioural upstream memories.
module tb_dense1_output_requant_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, up_done1, start2, up_done2;
  logic        up_start1, up_start2, busy1, busy2, done1, done2;
  logic [31:0] up_addr1, up_addr2, up_data1, up_data2, d2a;
  logic [6:0]  rd_addr1, rd_addr2, argmax1, argmax2;
  logic [7:0]  rd_data1, rd_data2, max_val1, max_val2;

  logic [31:0] mem1 [128];
  logic [31:0] mem2 [128];

  int n_cmp = 0;
  int n_bad = 0;
  int n_up1 = 0;

  typedef struct {
    logic [31:0] x;
    logic [7:0]  q;
  } vec_t;
  vec_t tbl [10];

  dense1_output_requant_reader #(.N_OUT(128), .SHIFT(8), .READ_LATENCY(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .start        (start1),
    .up_start     (up_start1),
    .up_done      (up_done1),
    .up_read_addr (up_addr1),
    .up_read_data (up_data1),
    .rd_addr      (rd_addr1),
    .rd_data      (rd_data1),
    .argmax       (argmax1),
    .max_val      (max_val1),
    .busy         (busy1),
    .done         (done1)
  );

  dense1_output_requant_reader #(.N_OUT(128), .SHIFT(8), .READ_LATENCY(2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .start        (start2),
    .up_start     (up_start2),
    .up_done      (up_done2),
    .up_read_addr (up_addr2),
    .up_read_data (up_data2),
    .rd_addr      (rd_addr2),
    .rd_data      (rd_data2),
    .argmax       (argmax2),
    .max_val      (max_val2),
    .busy         (busy2),
    .done         (done2)
  );

  // Upstream BRAM models: one and two registered stages.
  always @(posedge clk) up_data1 <= mem1[up_addr1[6:0]];
  always @(posedge clk) begin
    d2a      <= mem2[up_addr2[6:0]];
    up_data2 <= d2a;
  end

  always @(posedge clk) if (up_start1) n_up1 <= n_up1 + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_q(input logic [31:0] x);
    longint r, y;
    r = ($signed(x) < 0) ? 0 : longint'($signed(x));
    y = (r + 128) / 256;
    if (y > 127) y = 127;
    return 8'(y);
  endfunction

  // From WAIT_UP: raise up_done, count cycles until done; optional stray start pulses.
  task automatic finish_run1(input bit pulses, output int lat);
    repeat (2) @(negedge clk);
    if (pulses) begin
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
    @(negedge clk);
    up_done1 = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      up_done1 = 1'b0;
      start1   = pulses && (lat == 10);
    end while (!done1 && lat < 400);
    start1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_run1(input bit pulses, output int lat);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("up_start_high", 32'(up_start1), 32'd1);
    @(negedge clk);
    check("up_start_one_cycle", 32'(up_start1), 32'd0);
    check("busy_wait_up", 32'(busy1), 32'd1);
    finish_run1(pulses, lat);
  endtask

  task automatic fill_ramp1();
    for (int k = 0; k < 128; k++) mem1[k] = 32'(k * 256);
  endtask

  task automatic check_ramp1();
    for (int k = 0; k < 128; k++) begin
      rd_addr1 = 7'(k);
      #1;
      check($sformatf("ramp_rd[%0d]", k), 32'(rd_data1), 32'(k));
    end
    check("ramp_argmax", 32'(argmax1), 32'd127);
    check("ramp_max_val", 32'(max_val1), 32'd127);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, up_before, n, exp_arg;
    logic [7:0] exp_max, qk;

    tbl[0] = '{32'(-5000),   8'd0};
    tbl[1] = '{32'd127,      8'd0};
    tbl[2] = '{32'd128,      8'd1};
    tbl[3] = '{32'd383,      8'd1};
    tbl[4] = '{32'd384,      8'd2};
    tbl[5] = '{32'h7FFFFFFF, 8'd127};
    tbl[6] = '{32'd32767,    8'd127};
    tbl[7] = '{32'd32383,    8'd126};
    tbl[8] = '{32'h80000000, 8'd0};
    tbl[9] = '{32'd255,      8'd1};

    for (int k = 0; k < 128; k++) begin
      mem1[k] = '0;
      mem2[k] = '0;
    end
    start1 = 0; up_done1 = 0; start2 = 0; up_done2 = 0;
    rd_addr1 = '0; rd_addr2 = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_up_start", 32'(up_start1), 32'd0);
    check("rst_up_addr", up_addr1, 32'd0);
    check("rst_argmax", 32'(argmax1), 32'd0);
    check("rst_max_val", 32'(max_val1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Ramp x = k*256: rd_data[k] = k, 130-cycle latency.
    fill_ramp1();
    up_before = n_up1;
    do_run1(1'b0, lat);
    check("ramp_latency", 32'(lat), 32'd130);
    check("ramp_done", 32'(done1), 32'd1);
    check("ramp_busy", 32'(busy1), 32'd0);
    check("ramp_up_addr_hold", up_addr1, 32'd127);
    check("ramp_up_start_count", 32'(n_up1 - up_before), 32'd1);
    check_ramp1();

    // Rounding, ReLU and saturation vectors placed at indices 20..29.
    for (int k = 0; k < 128; k++) mem1[k] = '0;
    for (int i = 0; i < 10; i++) mem1[20 + i] = tbl[i].x;
    do_run1(1'b0, lat);
    check("tbl_latency", 32'(lat), 32'd130);
    for (int i = 0; i < 10; i++) begin
      rd_addr1 = 7'(20 + i);
      #1;
      check($sformatf("tbl_rd[%0d]", i), 32'(rd_data1), 32'(tbl[i].q));
    end
    rd_addr1 = 7'd0;
    #1;
    check("tbl_rd_zero", 32'(rd_data1), 32'd0);
    check("tbl_argmax", 32'(argmax1), 32'd25);
    check("tbl_max_val", 32'(max_val1), 32'd127);

    // Ties: lowest index wins.
    for (int k = 0; k < 128; k++) mem1[k] = '0;
    mem1[10] = 32'd1280;
    mem1[90] = 32'd1280;
    do_run1(1'b0, lat);
    check("tie_max_val", 32'(max_val1), 32'd5);
    check("tie_argmax", 32'(argmax1), 32'd10);

    // Stray starts in WAIT_UP and FETCH are ignored.
    fill_ramp1();
    up_before = n_up1;
    do_run1(1'b1, lat);
    check("stray_latency", 32'(lat), 32'd130);
    check("stray_up_start_count", 32'(n_up1 - up_before), 32'd1);
    check_ramp1();

    // Restart from DONE: done falls next cycle, one up_start.
    for (int k = 0; k < 128; k++) mem1[k] = '0;
    mem1[77] = 32'd2560;
    up_before = n_up1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    check("restart_done_low", 32'(done1), 32'd0);
    check("restart_up_start", 32'(up_start1), 32'd1);
    @(posedge clk);
    #1;
    check("restart_up_start_off", 32'(up_start1), 32'd0);
    finish_run1(1'b0, lat);
    check("restart_latency", 32'(lat), 32'd130);
    check("restart_up_start_count", 32'(n_up1 - up_before), 32'd1);
    check("restart_argmax", 32'(argmax1), 32'd77);
    check("restart_max_val", 32'(max_val1), 32'd10);

    // Reset mid-FETCH at index 60.
    fill_ramp1();
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    up_done1 = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      up_done1 = 1'b0;
      n++;
    end while (up_addr1 != 32'd60 && n < 400);
    check("rst_mid_reached_60", up_addr1, 32'd60);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy1), 32'd0);
    check("rst_mid_done", 32'(done1), 32'd0);
    check("rst_mid_up_start", 32'(up_start1), 32'd0);
    check("rst_mid_up_addr", up_addr1, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    up_before = n_up1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_up_start", 32'(n_up1 - up_before), 32'd0);
    check("rst_mid_idle", 32'(busy1), 32'd0);
    do_run1(1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd130);
    check_ramp1();

    // READ_LATENCY=2: upstream data changes every fetch cycle.
    for (int k = 0; k < 128; k++) mem2[k] = (k % 3 == 0) ? 32'(-(k * 100)) : 32'(k * 97 + 50);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    up_done2 = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      up_done2 = 1'b0;
    end while (!done2 && lat < 400);
    check("rl2_latency", 32'(lat), 32'd131);
    exp_max = model_q(mem2[0]);
    exp_arg = 0;
    for (int k = 0; k < 128; k++) begin
      qk = model_q(mem2[k]);
      if (qk > exp_max) begin
        exp_max = qk;
        exp_arg = k;
      end
      rd_addr2 = 7'(k);
      #1;
      check($sformatf("rl2_rd[%0d]", k), 32'(rd_data2), 32'(qk));
    end
    check("rl2_argmax", 32'(argmax2), 32'(exp_arg));
    check("rl2_max_val", 32'(max_val2), 32'(exp_max));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
